// File: rtl/kp_voice_alloc_if.sv
// Note-event stream from the MIDI/sequencer front end into the voice allocator.
interface kp_voice_alloc_if;
    logic        ev_valid;
    logic        ev_ready;
    logic        ev_note_on;
    logic [6:0]  ev_key;
    logic [6:0]  ev_vel;
    logic [11:0] ev_len;

    modport master (output ev_valid, ev_note_on, ev_key, ev_vel, ev_len, input ev_ready);
    modport slave  (input ev_valid, ev_note_on, ev_key, ev_vel, ev_len, output ev_ready);
endinterface

// File: rtl/kp_voice_alloc.sv
// Karplus-Strong voice allocator: retrigger held keys, fill free voices lowest first,
// and (with KP_VOICE_STEAL_EN defined) steal the oldest voice, otherwise drop the note.
module kp_voice_alloc #(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned AGE_W      = 16,
    parameter int unsigned TRIG_LEN   = 8
) (
    input  logic                       a_clk,
    input  logic                       reset_n,
    kp_voice_alloc_if.slave            ev,
    output logic [NUM_VOICES-1:0]      voice_trig,
    output logic [12*NUM_VOICES-1:0]   voice_len,
    output logic [7*NUM_VOICES-1:0]    voice_vel,
    output logic [NUM_VOICES-1:0]      voice_busy,
    output logic                       ev_steal,
    output logic                       ev_drop
);
    localparam int unsigned IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int unsigned CNT_W = $clog2(TRIG_LEN + 1);

    typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_ASSIGN, S_HOLD} state_t;

    state_t                    r_state, w_state_nxt;
    logic                      r_ready, r_on, r_evflag;
    logic [6:0]                r_key, r_vel;
    logic [11:0]               r_len;
    logic [IDX_W-1:0]          r_tgt, w_tgt;
    logic [CNT_W-1:0]          r_cnt;
    logic [NUM_VOICES-1:0]     r_trig, r_busy, w_trig_nxt, w_key_hit;
    logic [12*NUM_VOICES-1:0]  r_vlen;
    logic [7*NUM_VOICES-1:0]   r_vvel;
    logic [6:0]                r_vkey [NUM_VOICES];
    logic                      w_accept, w_match, w_free, w_hit;
    logic                      w_assign, w_clear, w_evflag_nxt, w_ready_nxt;
    logic [IDX_W-1:0]          w_match_idx, w_free_idx;

    assign w_accept = ev.ev_valid & r_ready & (r_state == S_IDLE);

    // Descending scan so the lowest matching / free index wins.
    always_comb begin
        w_match     = 1'b0;
        w_match_idx = '0;
        w_free      = 1'b0;
        w_free_idx  = '0;
        w_key_hit   = '0;
        for (int v = int'(NUM_VOICES) - 1; v >= 0; v--) begin
            if (r_busy[v] && (r_vkey[v] == r_key)) begin
                w_match      = 1'b1;
                w_match_idx  = IDX_W'(v);
                w_key_hit[v] = 1'b1;
            end
            if (!r_busy[v]) begin
                w_free     = 1'b1;
                w_free_idx = IDX_W'(v);
            end
        end
    end

`ifdef KP_VOICE_STEAL_EN
    // Age only matters when choosing a voice to steal.
    logic [AGE_W-1:0] r_age [NUM_VOICES];
    logic [AGE_W-1:0] w_old_age;
    logic [IDX_W-1:0] w_old_idx;

    always_comb begin
        w_old_age = r_age[0];
        w_old_idx = '0;
        for (int v = 1; v < int'(NUM_VOICES); v++) begin
            if (r_age[v] > w_old_age) begin
                w_old_age = r_age[v];
                w_old_idx = IDX_W'(v);
            end
        end
    end

    always_ff @(posedge a_clk) begin
        for (int v = 0; v < int'(NUM_VOICES); v++) begin
            if (!reset_n)
                r_age[v] <= '0;
            else if (w_assign && (w_tgt == IDX_W'(v)))
                r_age[v] <= '0;
            else if (r_age[v] != {AGE_W{1'b1}})
                r_age[v] <= r_age[v] + AGE_W'(1);
        end
    end

    assign w_hit = 1'b1;
    assign w_tgt = w_match ? w_match_idx : (w_free ? w_free_idx : w_old_idx);
`else
    assign w_hit = w_match | w_free;
    assign w_tgt = w_match ? w_match_idx : w_free_idx;
`endif

    always_ff @(posedge a_clk) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_state_nxt = S_SEARCH;
            S_SEARCH: w_state_nxt = (r_on && w_hit) ? S_ASSIGN : S_IDLE;
            S_ASSIGN: w_state_nxt = S_HOLD;
            S_HOLD:   if (r_cnt == CNT_W'(TRIG_LEN - 1)) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered outputs, decoded from state and search result.
    always_comb begin
        w_assign    = (r_state == S_SEARCH) & r_on & w_hit;
        w_clear     = (r_state == S_SEARCH) & ~r_on;
`ifdef KP_VOICE_STEAL_EN
        w_evflag_nxt = w_assign & ~w_match & ~w_free;
`else
        w_evflag_nxt = (r_state == S_SEARCH) & r_on & ~w_hit;
`endif
        w_trig_nxt  = (w_state_nxt == S_HOLD) ? (NUM_VOICES'(1) << r_tgt) : '0;
        w_ready_nxt = (w_state_nxt == S_IDLE);
    end

    always_ff @(posedge a_clk) begin
        if (!reset_n) begin
            r_ready  <= 1'b0;
            r_on     <= 1'b0;
            r_evflag <= 1'b0;
            r_key    <= '0;
            r_vel    <= '0;
            r_len    <= '0;
            r_tgt    <= '0;
            r_cnt    <= '0;
            r_trig   <= '0;
            r_busy   <= '0;
            r_vlen   <= '0;
            r_vvel   <= '0;
            for (int v = 0; v < int'(NUM_VOICES); v++) r_vkey[v] <= '0;
        end else begin
            r_ready  <= w_ready_nxt;
            r_evflag <= w_evflag_nxt;
            r_trig   <= w_trig_nxt;
            r_cnt    <= ((r_state == S_HOLD) && (w_state_nxt == S_HOLD)) ? r_cnt + CNT_W'(1) : '0;
            if (w_accept) begin
                r_on  <= ev.ev_note_on & (ev.ev_vel != 7'd0);
                r_key <= ev.ev_key;
                r_vel <= ev.ev_vel;
                r_len <= ev.ev_len;
            end
            if (r_state == S_SEARCH) r_tgt <= w_tgt;
            for (int v = 0; v < int'(NUM_VOICES); v++) begin
                if (w_clear && w_key_hit[v]) r_busy[v] <= 1'b0;
                if (w_assign && (w_tgt == IDX_W'(v))) begin
                    r_vlen[v*12 +: 12] <= r_len;
                    r_vvel[v*7 +: 7]   <= r_vel;
                    r_vkey[v]          <= r_key;
                    r_busy[v]          <= 1'b1;
                end
            end
        end
    end

    assign ev.ev_ready = r_ready;
    assign voice_trig  = r_trig;
    assign voice_len   = r_vlen;
    assign voice_vel   = r_vvel;
    assign voice_busy  = r_busy;
`ifdef KP_VOICE_STEAL_EN
    assign ev_steal = r_evflag;
    assign ev_drop  = 1'b0;
`else
    assign ev_steal = 1'b0;
    assign ev_drop  = r_evflag;
`endif
endmodule

// File: tb/tb_kp_voice_alloc.sv
// Directed bench for kp_voice_alloc (4 voices, TRIG_LEN 8); follows KP_VOICE_STEAL_EN.
module tb_kp_voice_alloc;
    localparam int N = 4;
`ifdef KP_VOICE_STEAL_EN
    localparam bit STEAL = 1'b1;
`else
    localparam bit STEAL = 1'b0;
`endif

    logic a_clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 a_clk = ~a_clk;

    kp_voice_alloc_if ev_if ();
    logic [N-1:0]    voice_trig, voice_busy;
    logic [12*N-1:0] voice_len;
    logic [7*N-1:0]  voice_vel;
    logic            ev_steal, ev_drop;

    kp_voice_alloc #(.NUM_VOICES(N), .AGE_W(16), .TRIG_LEN(8)) dut (
        .a_clk(a_clk), .reset_n(reset_n), .ev(ev_if),
        .voice_trig(voice_trig), .voice_len(voice_len), .voice_vel(voice_vel),
        .voice_busy(voice_busy), .ev_steal(ev_steal), .ev_drop(ev_drop));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    int              o_rdy_low, o_trig_cyc, o_first, o_steals, o_drops, o_multi;
    logic [N-1:0]    o_trig_or, o_busy0;
    logic [12*N-1:0] o_len_before;
    logic [7*N-1:0]  o_vel_before;

    task automatic wait_ready();
        int budget = 0;
        while (!ev_if.ev_ready && budget < 50) begin
            @(negedge a_clk);
            budget++;
        end
        chk("ready_before_send", 64'(ev_if.ev_ready), 64'd1);
    endtask

    // Send one event, then sample every cycle until ev_ready returns.
    task automatic send_obs(input bit on, input logic [6:0] key, input logic [6:0] vel,
                            input logic [11:0] len);
        int k;
        logic [12*N-1:0] plen;
        logic [7*N-1:0]  pvel;
        wait_ready();
        ev_if.ev_valid = 1'b1; ev_if.ev_note_on = on;
        ev_if.ev_key = key; ev_if.ev_vel = vel; ev_if.ev_len = len;
        @(posedge a_clk);
        @(negedge a_clk);
        ev_if.ev_valid = 1'b0;
        o_trig_cyc = 0; o_first = -1; o_steals = 0; o_drops = 0; o_multi = 0;
        o_trig_or = '0; o_busy0 = voice_busy; o_len_before = '0; o_vel_before = '0;
        plen = voice_len; pvel = voice_vel; k = 0;
        forever begin
            if (voice_trig != '0) begin
                o_trig_cyc++;
                o_trig_or |= voice_trig;
                if ($countones(voice_trig) > 1) o_multi++;
                if (o_first < 0) begin
                    o_first = k; o_len_before = plen; o_vel_before = pvel;
                end
            end
            if (ev_steal) o_steals++;
            if (ev_drop)  o_drops++;
            if (ev_if.ev_ready || k >= 40) break;
            plen = voice_len; pvel = voice_vel;
            @(negedge a_clk);
            k++;
        end
        o_rdy_low = k;
    endtask

    logic [6:0]  q_key [3] = '{7'd40, 7'd41, 7'd42};
    logic [11:0] q_len [3] = '{12'h140, 12'h148, 12'h150};
    logic [6:0]  f_key [3] = '{7'd62, 7'd64, 7'd65};
    logic [6:0]  f_vel [3] = '{7'd70, 7'd80, 7'd81};
    logic [11:0] f_len [3] = '{12'h1F0, 12'h200, 12'h208};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int accepts, qi;
        bit adv;
        logic [N-1:0] trig_acc;
        int q_steals, q_drops;
        logic [12*N-1:0] exp_len;
        logic [7*N-1:0]  exp_vel;

        ev_if.ev_valid = 1'b0; ev_if.ev_note_on = 1'b0;
        ev_if.ev_key = '0; ev_if.ev_vel = '0; ev_if.ev_len = '0;
        repeat (3) @(negedge a_clk);
        chk("rst_ready", 64'(ev_if.ev_ready), 64'd0);
        chk("rst_trig",  64'(voice_trig), 64'd0);
        chk("rst_busy",  64'(voice_busy), 64'd0);
        chk("rst_len",   64'(voice_len),  64'd0);
        chk("rst_flags", 64'({ev_steal, ev_drop}), 64'd0);
        reset_n = 1'b1;
        @(negedge a_clk);
        chk("ready_after_rst", 64'(ev_if.ev_ready), 64'd1);

        send_obs(1'b1, 7'd60, 7'd100, 12'h2E0);
        chk("on60_ready_low",  64'(o_rdy_low), 64'd10);
        chk("on60_trig_cyc",   64'(o_trig_cyc), 64'd8);
        chk("on60_trig_lat",   64'(o_first), 64'd2);
        chk("on60_len_early",  64'(o_len_before[11:0]), 64'h2E0);
        chk("on60_vel_early",  64'(o_vel_before[6:0]), 64'd100);
        chk("on60_trig_voice", 64'(o_trig_or), 64'b0001);
        chk("on60_busy",       64'(voice_busy), 64'b0001);

        for (int i = 0; i < 3; i++) begin
            send_obs(1'b1, f_key[i], f_vel[i], f_len[i]);
            chk($sformatf("fill%0d_voice", i + 1), 64'(o_trig_or), 64'(4'b0001 << (i + 1)));
            chk($sformatf("fill%0d_multi", i + 1), 64'(o_multi), 64'd0);
        end
        chk("fill_busy", 64'(voice_busy), 64'b1111);
        chk("fill_len1", 64'(voice_len[23:12]), 64'h1F0);

        send_obs(1'b1, 7'd62, 7'd50, 12'h123);
        chk("retrig_voice", 64'(o_trig_or), 64'b0010);
        chk("retrig_vel",   64'(voice_vel[13:7]), 64'd50);
        chk("retrig_len",   64'(voice_len[23:12]), 64'h123);
        chk("retrig_steal", 64'(o_steals), 64'd0);
        chk("retrig_busy",  64'(voice_busy), 64'b1111);

        send_obs(1'b1, 7'd70, 7'd90, 12'h230);
        exp_len = {12'h208, 12'h200, 12'h123, (STEAL ? 12'h230 : 12'h2E0)};
        exp_vel = {7'd81, 7'd80, 7'd50, (STEAL ? 7'd90 : 7'd100)};
        chk("full_trig",  64'(o_trig_or), STEAL ? 64'b0001 : 64'd0);
        chk("full_steal", 64'(o_steals), STEAL ? 64'd1 : 64'd0);
        chk("full_drop",  64'(o_drops),  STEAL ? 64'd0 : 64'd1);
        chk("full_ready_low", 64'(o_rdy_low), STEAL ? 64'd10 : 64'd1);
        chk("full_len", 64'(voice_len), 64'(exp_len));
        chk("full_vel", 64'(voice_vel), 64'(exp_vel));

        send_obs(1'b0, 7'd64, 7'd0, 12'h000);
        chk("off64_busy_search", 64'(o_busy0), 64'b1111);
        chk("off64_busy",        64'(voice_busy), 64'b1011);
        chk("off64_ready_low",   64'(o_rdy_low), 64'd1);
        chk("off64_trig",        64'(o_trig_cyc), 64'd0);
        chk("off64_len",         64'(voice_len), 64'(exp_len));

        send_obs(1'b0, 7'd99, 7'd0, 12'h000);
        chk("off99_busy", 64'(voice_busy), 64'b1011);
        chk("off99_trig", 64'(o_trig_cyc), 64'd0);
        chk("off99_vel",  64'(voice_vel), 64'(exp_vel));

        send_obs(1'b1, 7'd65, 7'd0, 12'h3FF);
        chk("vel0_busy", 64'(voice_busy), 64'b0011);
        chk("vel0_trig", 64'(o_trig_cyc), 64'd0);
        chk("vel0_ready_low", 64'(o_rdy_low), 64'd1);
        chk("vel0_len", 64'(voice_len), 64'(exp_len));

        // Three queued events with ev_valid held high throughout.
        accepts = 0; qi = 0; adv = 1'b0; trig_acc = '0; q_steals = 0; q_drops = 0;
        ev_if.ev_valid = 1'b1; ev_if.ev_note_on = 1'b1; ev_if.ev_vel = 7'd60;
        ev_if.ev_key = q_key[0]; ev_if.ev_len = q_len[0];
        for (int c = 0; c < 300; c++) begin
            if (c > 0) @(negedge a_clk);
            if (adv) begin
                adv = 1'b0;
                qi++;
                if (qi < 3) begin
                    ev_if.ev_key = q_key[qi]; ev_if.ev_len = q_len[qi];
                end else begin
                    ev_if.ev_valid = 1'b0;
                end
            end
            trig_acc |= voice_trig;
            if (ev_steal) q_steals++;
            if (ev_drop)  q_drops++;
            if (ev_if.ev_valid && ev_if.ev_ready) begin
                accepts++;
                adv = 1'b1;
            end
            if (qi >= 3 && ev_if.ev_ready) break;
        end
        chk("queue_accepts", 64'(accepts), 64'd3);
        chk("queue_trig",    64'(trig_acc), STEAL ? 64'b1110 : 64'b1100);
        chk("queue_flags",   64'(q_steals + 2 * q_drops), STEAL ? 64'd1 : 64'd2);
        chk("queue_len2",    64'(voice_len[35:24]), 64'h140);
        chk("queue_len3",    64'(voice_len[47:36]), 64'h148);
        chk("queue_len1",    64'(voice_len[23:12]), STEAL ? 64'h150 : 64'h123);
        chk("queue_busy",    64'(voice_busy), 64'b1111);

        send_obs(1'b0, 7'd40, 7'd0, 12'h000);
        chk("off40_busy", 64'(voice_busy), 64'b1011);

        // Reset during the third cycle of trigger hold.
        wait_ready();
        ev_if.ev_valid = 1'b1; ev_if.ev_note_on = 1'b1;
        ev_if.ev_key = 7'd50; ev_if.ev_vel = 7'd77; ev_if.ev_len = 12'h2A0;
        @(posedge a_clk);
        @(negedge a_clk);
        ev_if.ev_valid = 1'b0;
        repeat (4) @(negedge a_clk);
        chk("hold3_trig", 64'(voice_trig), 64'b0100);
        reset_n = 1'b0;
        @(negedge a_clk);
        chk("midrst_trig",  64'(voice_trig), 64'd0);
        chk("midrst_busy",  64'(voice_busy), 64'd0);
        chk("midrst_ready", 64'(ev_if.ev_ready), 64'd0);
        reset_n = 1'b1;
        @(negedge a_clk);
        chk("postrst_ready", 64'(ev_if.ev_ready), 64'd1);
        chk("postrst_len",   64'(voice_len), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/kp_voice_alloc.md
Name: kp_voice_alloc

Overview:
- Voice allocator/scheduler that shares a bank of NUM_VOICES Karplus-Strong voice engines between one stream of note events from the MIDI/sequencer front end.
- Per voice, drives the trigger, velocity and tuning word (delay_length) inputs.
- Tracks which voice holds which key.
- Retriggers repeated keys, fills free voices lowest-index first, and steals the oldest voice when all are busy.

Parameters:
- NUM_VOICES, 4, number of KP voice engines driven (2..8).
- AGE_W, 16, width of per-voice saturating age counter.
- TRIG_LEN, 8, a_clk cycles each trigger is held high (must be ≥4 to pass the voice's trigger debounce).

Ports:
- a_clk  in  1  audio clock (96 kHz domain).
- reset_n  in  1  synchronous, active-low reset.
- ev_valid  in  1  note event available.
- ev_ready  out  1  allocator can accept an event.
- ev_note_on  in  1  1 = note-on, 0 = note-off.
- ev_key  in  7  MIDI key number.
- ev_vel  in  7  MIDI velocity.
- ev_len  in  12  tuning word for ev_key (from upstream tuning table).
- voice_trig  out  NUM_VOICES  per-voice trigger, active-high.
- voice_len  out  12*NUM_VOICES  per-voice delay_length; voice v occupies bits [12v+11:12v].
- voice_vel  out  7*NUM_VOICES  per-voice velocity; voice v occupies bits [7v+6:7v].
- voice_busy  out  NUM_VOICES  voice holds a key (note-on received, no matching note-off yet).
- ev_steal  out  1  one-cycle pulse: a busy voice was stolen.
- ev_drop  out  1  one-cycle pulse: note-on discarded (only without KP_VOICE_STEAL_EN).

Behaviour:
- Reset (synchronous, reset_n low at a_clk edge) clears the following to 0: all outputs, per-voice key registers, age counters, and the FSM, which goes to IDLE. Reset mid-trigger drops voice_trig on that same edge.
- Handshake: ev_ready = 1 only in IDLE. The event is accepted on ev_valid & ev_ready, and ev_key/ev_vel/ev_len are registered on acceptance. While ev_ready = 0, upstream holds the event.
- Note-on with ev_vel = 0 is treated as note-off.
- FSM states: IDLE → SEARCH → {ASSIGN → HOLD → IDLE | IDLE}.
- SEARCH (1 cycle) selects the target voice, first matching rule wins:
  - (a) busy voice with key == ev_key, lowest index;
  - (b) lowest-index non-busy voice;
  - (c) voice with largest age, ties to lowest index (steal).
- Note-off in SEARCH:
  - Clears voice_busy of every voice whose key matches.
  - No trigger; voice_len and voice_vel are unchanged (the string decays naturally).
  - Returns to IDLE.
  - No match → ignored.
- ASSIGN (1 cycle) writes for the target voice:
  - voice_len, voice_vel and key;
  - voice_busy = 1;
  - age = 0.
  - It also pulses ev_steal if rule (c) applied.
- voice_trig[target] rises on the cycle after ASSIGN, so len/vel are stable at least 1 cycle before the trigger edge.
- HOLD: voice_trig[target] high for exactly TRIG_LEN cycles, then low, then IDLE. Only one voice_trig bit is ever high.
- Latencies:
  - Note-on: acceptance to trigger rise = 2 cycles; ev_ready low for TRIG_LEN+2 cycles.
  - Note-off: ev_ready low for 1 cycle.
- Age: every voice's age increments each a_clk, saturating at 2^AGE_W−1. It is zeroed only by ASSIGN.
- Retrigger (rule a) re-latches len/vel and zeroes age. It does not pulse ev_steal.
- Voices beyond the last used index keep constant outputs.

Optional Feature:
- Macro KP_VOICE_STEAL_EN.
- Defined: rule (c) active as above; ev_drop is tied to 0.
- Undefined:
  - When rules (a) and (b) both fail, the note-on is accepted and discarded: no voice state change, no trigger.
  - ev_drop pulses for 1 cycle in SEARCH, and the FSM returns to IDLE.
  - ev_steal is tied to 0.

Test Plan:
- Reset then note-on key 60, vel 100, len 0x2E0 → ev_ready low 10 cycles (TRIG_LEN=8); voice_len[11:0]=0x2E0 and voice_vel[6:0]=100 one cycle before voice_trig=0001; voice_trig high 8 cycles; voice_busy=0001.
- Note-ons keys 60,62,64,65 back-to-back → voices 0,1,2,3 in order, busy=1111; then key 62 note-on vel 50 → retrigger voice 1 only, voice_vel[13:7]=50, ev_steal=0.
- All four busy, fifth note-on key 70 → voice 0 (oldest) reassigned, ev_steal pulses once; with KP_VOICE_STEAL_EN undefined instead ev_drop pulses, no voice_trig, all voice regs unchanged.
- Note-off key 64 → voice_busy[2] clears after 1 cycle busy, no trigger; note-off key 99 (unmatched) → no state change; note-on key 72 vel 0 behaves as note-off.
- Hold ev_valid high with 3 queued events → exactly one acceptance per IDLE visit, none while ev_ready=0.
- Assert reset_n low during HOLD cycle 3 → voice_trig=0, voice_busy=0, ev_ready=0 on that edge; ev_ready=1 one cycle after reset_n returns high.
